// File: rtl/unified_mem_arbiter_if.sv
// Bus bundle for the unified memory arbiter: fetch port, data port and memory side.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface unified_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_flush;
    logic              i_ready;
    logic              i_rvalid;
    logic [DATA_W-1:0] i_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ready;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  i_req, i_addr, i_flush, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output i_ready, i_rvalid, i_rdata, d_ready, d_rvalid, d_rdata,
               mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output i_req, i_addr, i_flush, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  i_ready, i_rvalid, i_rdata, d_ready, d_rvalid, d_rdata,
               mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Arbitrates fetch (I) and data (D) ports onto one fixed-latency memory, one access at a time.
// D has priority; a saturating starvation counter forces an I grant after STARVE_LIMIT D grants.
module unified_mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MEM_LATENCY  = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    unified_mem_arbiter_if.slave    bus,
    output logic                    busy
);
    localparam int LW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [LW-1:0] LAT_INIT   = LW'(MEM_LATENCY - 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [LW-1:0]     lat_q, lat_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic              own_i_q, own_i_d;
    logic              we_q, we_d;
    logic              cancel_q, cancel_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

    logic              i_gnt_s, d_gnt_s, force_i_s;
    logic              i_rvalid_s, d_rvalid_s;
    logic [ADDR_W-1:0] mem_addr_s;
    logic [DATA_W-1:0] mem_wdata_s;

    assign force_i_s = (STARVE_LIMIT != 0) && (starve_q == STARVE_MAX);

    // Next-state, arbitration and per-state outputs.
    always_comb begin
        state_d     = state_q;
        lat_d       = lat_q;
        own_i_d     = own_i_q;
        we_d        = we_q;
        cancel_d    = cancel_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        i_gnt_s     = 1'b0;
        d_gnt_s     = 1'b0;
        i_rvalid_s  = 1'b0;
        d_rvalid_s  = 1'b0;
        mem_addr_s  = addr_q;
        mem_wdata_s = wdata_q;
        case (state_q)
            IDLE: begin
                i_gnt_s     = bus.i_req && !bus.i_flush && (!bus.d_req || force_i_s);
                d_gnt_s     = bus.d_req && !i_gnt_s;
                mem_addr_s  = {ADDR_W{1'b0}};
                mem_wdata_s = {DATA_W{1'b0}};
                if (i_gnt_s || d_gnt_s) begin
                    state_d     = BUSY;
                    lat_d       = LAT_INIT;
                    own_i_d     = i_gnt_s;
                    we_d        = d_gnt_s && bus.d_we;
                    cancel_d    = 1'b0;
                    addr_d      = i_gnt_s ? bus.i_addr : bus.d_addr;
                    wdata_d     = d_gnt_s ? bus.d_wdata : {DATA_W{1'b0}};
                    mem_addr_s  = addr_d;
                    mem_wdata_s = wdata_d;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (own_i_q && bus.i_flush) begin
                    cancel_d = 1'b1;
                end else begin
                    cancel_d = cancel_q;
                end
                // Memory data is only valid in the final BUSY cycle.
                if (lat_q == {LW{1'b0}}) begin
                    state_d = RESP;
                    if (own_i_q) begin
                        i_rdata_d = bus.mem_rdata;
                    end else begin
                        d_rdata_d = we_q ? {DATA_W{1'b0}} : bus.mem_rdata;
                    end
                end else begin
                    lat_d = lat_q - LW'(1);
                end
            end
            RESP: begin
                state_d    = IDLE;
                cancel_d   = 1'b0;
                i_rvalid_s = own_i_q && !cancel_q && !bus.i_flush;
                d_rvalid_s = !own_i_q;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (!bus.i_req || i_gnt_s) begin
            starve_d = {SW{1'b0}};
        end else if (d_gnt_s && (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + SW'(1);
        end else begin
            starve_d = starve_q;
        end
    end

    // State and datapath registers; reset drops any in-flight access.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            lat_q     <= {LW{1'b0}};
            starve_q  <= {SW{1'b0}};
            own_i_q   <= 1'b0;
            we_q      <= 1'b0;
            cancel_q  <= 1'b0;
            addr_q    <= {ADDR_W{1'b0}};
            wdata_q   <= {DATA_W{1'b0}};
            i_rdata_q <= {DATA_W{1'b0}};
            d_rdata_q <= {DATA_W{1'b0}};
        end else begin
            state_q   <= state_d;
            lat_q     <= lat_d;
            starve_q  <= starve_d;
            own_i_q   <= own_i_d;
            we_q      <= we_d;
            cancel_q  <= cancel_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    assign bus.i_ready   = i_gnt_s;
    assign bus.d_ready   = d_gnt_s;
    assign bus.i_rvalid  = i_rvalid_s;
    assign bus.d_rvalid  = d_rvalid_s;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.mem_req   = i_gnt_s || d_gnt_s;
    assign bus.mem_we    = d_gnt_s && bus.d_we;
    assign bus.mem_addr  = mem_addr_s;
    assign bus.mem_wdata = mem_wdata_s;
    assign busy          = (state_q != IDLE);
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed-vector bench for unified_mem_arbiter (MEM_LATENCY=4, STARVE_LIMIT=3) with a
// fixed-latency memory model that only presents real data in the final BUSY cycle.
module tb_unified_mem_arbiter;
    localparam int LAT = 4;

    logic clk = 1'b0;
    logic reset;
    logic busy;
    int   vec_cnt  = 0;
    int   miss_cnt = 0;
    int   mreq_cnt = 0;
    int   gnt_cnt  = 0;
    int   both_cnt = 0;
    byte  glog[$];
    int   mcnt;
    logic [31:0] maddr;

    unified_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    unified_mem_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MEM_LATENCY(LAT), .STARVE_LIMIT(3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a == 32'h0000_0010) ? 32'hDEAD_BEEF : {a[15:0], 16'hC0DE};
    endfunction

    // Fixed-latency memory: data valid only LAT cycles after mem_req.
    always @(posedge clk) begin
        if (reset) begin
            mcnt <= 0;
        end else if (bus.mem_req) begin
            mcnt  <= 1;
            maddr <= bus.mem_addr;
        end else if (mcnt != 0) begin
            mcnt <= (mcnt == LAT) ? 0 : mcnt + 1;
        end
    end
    assign bus.mem_rdata = (mcnt == LAT) ? mem_fn(maddr) : 32'hBAD0_BAD0;

    // Grant log and bookkeeping, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.d_ready) glog.push_back(8'h44);
        if (bus.i_ready) glog.push_back(8'h49);
        if (bus.mem_req) mreq_cnt <= mreq_cnt + 1;
        if (bus.i_ready || bus.d_ready) gnt_cnt <= gnt_cnt + 1;
        if (bus.i_ready && bus.d_ready) both_cnt <= both_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        string exp_order = "DDDIDDDI";
        reset = 1'b1;
        bus.i_req = 1'b0; bus.i_addr = 32'h0; bus.i_flush = 1'b0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = 32'h0; bus.d_wdata = 32'h0;
        step; step;
        smp;
        chk("rst_busy", busy, 1'b0);
        chk("rst_i_ready", bus.i_ready, 1'b0);
        chk("rst_d_ready", bus.d_ready, 1'b0);
        chk("rst_mem_req", bus.mem_req, 1'b0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        chk("rst_i_rdata", bus.i_rdata, 32'h0);
        chk("rst_d_rdata", bus.d_rdata, 32'h0);
        step; reset = 1'b0;

        // Single fetch: accept at T0, data at T5.
        step; bus.i_req = 1'b1; bus.i_addr = 32'h10;
        smp;
        chk("t1_i_ready", bus.i_ready, 1'b1);
        chk("t1_d_ready", bus.d_ready, 1'b0);
        chk("t1_mem_req", bus.mem_req, 1'b1);
        chk("t1_mem_we", bus.mem_we, 1'b0);
        chk("t1_mem_addr", bus.mem_addr, 32'h10);
        chk("t1_busy_t0", busy, 1'b0);
        for (int c = 1; c <= 5; c++) begin
            step; bus.i_req = 1'b0;
            smp;
            chk("t1_busy", busy, 1'b1);
            chk("t1_i_rvalid", bus.i_rvalid, (c == 5));
            chk("t1_i_ready_busy", bus.i_ready, 1'b0);
            if (c == 2) chk("t1_mem_addr_held", bus.mem_addr, 32'h10);
            if (c == 5) chk("t1_i_rdata", bus.i_rdata, 32'hDEAD_BEEF);
        end
        step; smp;
        chk("t1_idle", busy, 1'b0);
        chk("t1_rdata_hold", bus.i_rdata, 32'hDEAD_BEEF);

        // Both request: D first, then I in the next IDLE.
        step;
        bus.i_req = 1'b1; bus.i_addr = 32'h80;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h200;
        smp;
        chk("t2_d_ready", bus.d_ready, 1'b1);
        chk("t2_i_ready", bus.i_ready, 1'b0);
        chk("t2_mem_addr", bus.mem_addr, 32'h200);
        for (int c = 1; c <= 5; c++) begin
            step; bus.d_req = 1'b0;
            smp;
            chk("t2_i_ready_wait", bus.i_ready, 1'b0);
            chk("t2_d_rvalid", bus.d_rvalid, (c == 5));
            if (c == 5) chk("t2_d_rdata", bus.d_rdata, 32'h0200_C0DE);
        end
        step; smp;
        chk("t2_i_ready", bus.i_ready, 1'b1);
        chk("t2_i_mem_addr", bus.mem_addr, 32'h80);
        for (int c = 1; c <= 5; c++) begin
            step; bus.i_req = 1'b0;
            smp;
            chk("t2_i_rvalid", bus.i_rvalid, (c == 5));
            if (c == 5) chk("t2_i_rdata", bus.i_rdata, 32'h0080_C0DE);
        end

        // Flush of an in-flight fetch at T2.
        step; bus.i_req = 1'b1; bus.i_addr = 32'h10;
        smp;
        chk("t4_i_ready", bus.i_ready, 1'b1);
        for (int c = 1; c <= 5; c++) begin
            step; bus.i_req = 1'b0; bus.i_flush = (c == 2);
            smp;
            chk("t4_i_rvalid_cancel", bus.i_rvalid, 1'b0);
            if (c == 5) chk("t4_busy_resp", busy, 1'b1);
        end
        step; bus.i_flush = 1'b0; bus.i_req = 1'b1; bus.i_addr = 32'h20;
        smp;
        chk("t4_regrant_t6", bus.i_ready, 1'b1);
        for (int c = 1; c <= 5; c++) begin
            step; bus.i_req = 1'b0;
            smp;
            chk("t4_next_rvalid", bus.i_rvalid, (c == 5));
            if (c == 5) chk("t4_next_rdata", bus.i_rdata, 32'h0020_C0DE);
        end

        // Flush in IDLE blocks fetch only; it does not affect D.
        step; bus.i_req = 1'b1; bus.i_addr = 32'h30; bus.i_flush = 1'b1;
        smp;
        chk("fl_i_ready", bus.i_ready, 1'b0);
        chk("fl_mem_req", bus.mem_req, 1'b0);
        step; bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h500;
        smp;
        chk("fl_d_ready", bus.d_ready, 1'b1);
        for (int c = 1; c <= 5; c++) begin
            step; bus.d_req = 1'b0;
            smp;
            chk("fl_d_rvalid", bus.d_rvalid, (c == 5));
            if (c == 5) chk("fl_d_rdata", bus.d_rdata, 32'h0500_C0DE);
        end
        step; bus.i_flush = 1'b0;
        smp;
        chk("fl_i_ready_after", bus.i_ready, 1'b1);
        for (int c = 1; c <= 5; c++) begin
            step; bus.i_req = 1'b0;
            smp;
            if (c == 5) chk("fl_i_rdata", bus.i_rdata, 32'h0030_C0DE);
        end

        // Store: write strobes at T0, ack with zero data at T5.
        step;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h40; bus.d_wdata = 32'h1234_5678;
        smp;
        chk("t5_d_ready", bus.d_ready, 1'b1);
        chk("t5_mem_we", bus.mem_we, 1'b1);
        chk("t5_mem_addr", bus.mem_addr, 32'h40);
        chk("t5_mem_wdata", bus.mem_wdata, 32'h1234_5678);
        for (int c = 1; c <= 5; c++) begin
            step; bus.d_req = 1'b0; bus.d_we = 1'b0;
            smp;
            chk("t5_d_rvalid", bus.d_rvalid, (c == 5));
            if (c == 2) chk("t5_wdata_held", bus.mem_wdata, 32'h1234_5678);
            if (c == 5) chk("t5_d_rdata", bus.d_rdata, 32'h0);
        end

        // Starvation guard with both requesters held.
        step; glog.delete();
        bus.i_req = 1'b1; bus.i_addr = 32'h300;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h400;
        for (int k = 0; k < 200 && glog.size() < 8; k++) smp;
        step; bus.i_req = 1'b0; bus.d_req = 1'b0;
        for (int k = 0; k < 20 && busy; k++) smp;
        chk("t3_grant_count", glog.size(), 8);
        for (int k = 0; k < 8; k++) begin
            if (k < glog.size()) chk("t3_order", glog[k], exp_order[k]);
            else chk("t3_order_missing", 32'hFFFF_FFFF, exp_order[k]);
        end

        // Reset in the middle of a load.
        step; bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h600;
        smp;
        chk("t6_d_ready", bus.d_ready, 1'b1);
        step; bus.d_req = 1'b0;
        step; reset = 1'b1;
        smp;
        chk("t6_busy_pre", busy, 1'b1);
        step; smp;
        chk("t6_busy", busy, 1'b0);
        chk("t6_i_rdata", bus.i_rdata, 32'h0);
        chk("t6_d_rdata", bus.d_rdata, 32'h0);
        chk("t6_mem_addr", bus.mem_addr, 32'h0);
        chk("t6_mem_wdata", bus.mem_wdata, 32'h0);
        chk("t6_d_rvalid", bus.d_rvalid, 1'b0);
        step; reset = 1'b0; bus.d_req = 1'b1; bus.d_addr = 32'h700;
        smp;
        chk("t6_new_d_ready", bus.d_ready, 1'b1);
        for (int c = 1; c <= 5; c++) begin
            step; bus.d_req = 1'b0;
            smp;
            chk("t6_d_rvalid_new", bus.d_rvalid, (c == 5));
            if (c == 5) chk("t6_d_rdata_new", bus.d_rdata, 32'h0700_C0DE);
        end

        step; smp;
        chk("one_mem_req_per_grant", mreq_cnt, gnt_cnt);
        chk("never_both_ready", both_cnt, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end
endmodule
